// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the single data-memory port.
// m0 is the CPU load/store path, m1 the auxiliary (loader/VGA/PS2 DMA) master.
// Grants are combinational from the owner state and the live requests; a
// round-robin burst limit keeps one master from starving the other, and every
// read is tagged so its data returns only to the master that issued it.
module data_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // master 0 (cpu)
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_memop,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1 (auxiliary)
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_memop,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_memop,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;      // 0 = m0 wins a tie out of IDLE
  logic [CNT_W-1:0] burst_q, burst_d;

  logic gnt0, gnt1;
  logic xfer0, xfer1;
  logic rd_xfer, rd_owner;

  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_own_q, pipe_own_d;

  // Grant decision; held off entirely while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_IDLE: begin
          if (m0_req && m1_req) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
          end else if (m0_req) begin
            gnt0 = 1'b1;
          end else if (m1_req) begin
            gnt1 = 1'b1;
          end
        end
        ST_OWN0: begin
          if (m0_req && (!m1_req || (burst_q < BURST_MAX))) gnt0 = 1'b1;
          else if (m1_req)                                   gnt1 = 1'b1;
        end
        ST_OWN1: begin
          if (m1_req && (!m0_req || (burst_q < BURST_MAX))) gnt1 = 1'b1;
          else if (m0_req)                                   gnt0 = 1'b1;
        end
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  // Next owner, burst length and tie-break priority follow the grant.
  always_comb begin
    state_d = ST_IDLE;
    burst_d = '0;
    prio_d  = prio_q;
    if (gnt0) begin
      state_d = ST_OWN0;
      prio_d  = 1'b1;
      if (state_q == ST_OWN0)
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
      else
        burst_d = CNT_W'(1);
    end else if (gnt1) begin
      state_d = ST_OWN1;
      prio_d  = 1'b0;
      if (state_q == ST_OWN1)
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
      else
        burst_d = CNT_W'(1);
    end
  end

  // Owner state, priority and burst counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      burst_q <= burst_d;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;
  assign xfer0  = gnt0 & m0_req;
  assign xfer1  = gnt1 & m1_req;

  // Memory port carries the granted master's fields, zero when nobody owns it.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_memop = '0;
    mem_we    = 1'b0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_memop = m0_memop;
      mem_we    = xfer0 & m0_we;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_memop = m1_memop;
      mem_we    = xfer1 & m1_we;
    end
  end

  assign rd_xfer  = (xfer0 & ~m0_we) | (xfer1 & ~m1_we);
  assign rd_owner = xfer1;

  // Shift-in of the read tag; a single-stage pipe has no older stage to carry.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign pipe_vld_d = rd_xfer;
      assign pipe_own_d = rd_owner;
    end else begin : g_latn
      assign pipe_vld_d = {pipe_vld_q[RD_LAT-2:0], rd_xfer};
      assign pipe_own_d = {pipe_own_q[RD_LAT-2:0], rd_owner};
    end
  endgenerate

  // Read tag pipe; reset discards anything still in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
      pipe_own_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_own_q <= pipe_own_d;
    end
  end

  assign m0_rvalid = pipe_vld_q[RD_LAT-1] & ~pipe_own_q[RD_LAT-1];
  assign m1_rvalid = pipe_vld_q[RD_LAT-1] &  pipe_own_q[RD_LAT-1];
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed grant/port checks plus a read-return
// scoreboard fed when read requests are driven and drained on rvalid.
module tb_data_bus_arbiter;

  logic        clock;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_memop, m1_memop;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_memop;
  logic        mem_we;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  // memory model: words written through the port, else a fixed init pattern
  logic [31:0] wmem    [256];
  bit          written [256];

  data_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_BURST(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_memop  (m0_memop),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_memop  (m1_memop),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_memop (mem_memop),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h04:  return 32'h11111111;
      32'h08:  return 32'h22222222;
      32'h0C:  return 32'h33333333;
      default: return a * 3;
    endcase
  endfunction

  // One-cycle read latency memory.
  always @(posedge clock) begin
    mem_rdata <= written[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : init_word(mem_addr);
    if (mem_we) begin
      wmem[mem_addr[9:2]]    <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_rd(input logic owner, input logic [31:0] data);
    sb_t e;
    e.owner = owner;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  task automatic next_slot();
    @(posedge clock);
    #1;
  endtask

  // Exclusive grant every cycle; read returns popped against the scoreboard.
  always @(negedge clock) begin
    check_val("gnt_excl", {63'd0, m0_gnt & m1_gnt}, 64'd0);
    if (m0_rvalid || m1_rvalid) begin
      if (sb_q.size() == 0) begin
        check_val("rv_unexpected", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check_val("rv_owner", {62'd0, m0_rvalid, m1_rvalid}, e.owner ? 64'd1 : 64'd2);
        check_val("rv_data", {32'd0, e.owner ? m1_rdata : m0_rdata}, {32'd0, e.data});
        $display("read return owner=m%0d data=%08h", e.owner, e.owner ? m1_rdata : m0_rdata);
      end
    end
  end

  initial begin
    // 1: reset with both masters requesting
    reset_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hAAAA; m0_memop = 3'd0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h104; m1_wdata = 32'hBBBB; m1_memop = 3'd0;
    @(negedge clock);
    check_val("rst_m0_gnt", {63'd0, m0_gnt}, 64'd0);
    check_val("rst_m1_gnt", {63'd0, m1_gnt}, 64'd0);
    check_val("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check_val("rst_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
    check_val("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    next_slot();
    reset_n = 1'b1;
    @(negedge clock);
    check_val("rel_m0_gnt", {63'd0, m0_gnt}, 64'd1);
    check_val("rel_m1_gnt", {63'd0, m1_gnt}, 64'd0);

    // 2: m0 read of 0x10
    next_slot();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    push_rd(1'b0, 32'hDEADBEEF);
    @(negedge clock);
    check_val("t2_m0_gnt", {63'd0, m0_gnt}, 64'd1);
    check_val("t2_mem_addr", {32'd0, mem_addr}, 64'h10);
    check_val("t2_mem_we", {63'd0, mem_we}, 64'd0);
    next_slot();
    m0_req = 1'b0;
    @(negedge clock);
    check_val("t2_m0_rvalid", {63'd0, m0_rvalid}, 64'd1);
    check_val("t2_m1_rvalid", {63'd0, m1_rvalid}, 64'd0);
    next_slot();
    @(negedge clock);
    check_val("t2_rvalid_pulse", {63'd0, m0_rvalid}, 64'd0);
    check_val("t2_rdata_idle", {32'd0, m0_rdata}, 64'd0);

    // 3: m1 write of 0x1234 to 0x20
    next_slot();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234; m1_memop = 3'b010;
    @(negedge clock);
    check_val("t3_m1_gnt", {63'd0, m1_gnt}, 64'd1);
    check_val("t3_m0_gnt", {63'd0, m0_gnt}, 64'd0);
    check_val("t3_mem_we", {63'd0, mem_we}, 64'd1);
    check_val("t3_mem_addr", {32'd0, mem_addr}, 64'h20);
    check_val("t3_mem_wdata", {32'd0, mem_wdata}, 64'h1234);
    check_val("t3_mem_memop", {61'd0, mem_memop}, 64'd2);
    next_slot();
    m1_req = 1'b0;
    @(negedge clock);
    check_val("t3_mem_we_off", {63'd0, mem_we}, 64'd0);

    // 4: both masters writing continuously, bursts of 4
    next_slot();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hA0; m0_memop = 3'd0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_wdata = 32'hB0; m1_memop = 3'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check_val($sformatf("t4_m0_gnt_%0d", i), {63'd0, m0_gnt}, ((i / 4) % 2 == 0) ? 64'd1 : 64'd0);
      check_val($sformatf("t4_m1_gnt_%0d", i), {63'd0, m1_gnt}, ((i / 4) % 2 == 1) ? 64'd1 : 64'd0);
      next_slot();
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // 5: alternating back-to-back reads, including the word m1 wrote
    next_slot();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    push_rd(1'b0, 32'h11111111);
    @(negedge clock);
    check_val("t5_gnt_a", {62'd0, m0_gnt, m1_gnt}, 64'd2);
    next_slot();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
    push_rd(1'b1, 32'h22222222);
    @(negedge clock);
    check_val("t5_gnt_b", {62'd0, m0_gnt, m1_gnt}, 64'd1);
    next_slot();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 32'hC;
    push_rd(1'b0, 32'h33333333);
    @(negedge clock);
    check_val("t5_gnt_c", {62'd0, m0_gnt, m1_gnt}, 64'd2);
    next_slot();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h20;
    push_rd(1'b1, 32'h1234);
    @(negedge clock);
    check_val("t5_gnt_d", {62'd0, m0_gnt, m1_gnt}, 64'd1);
    next_slot();
    m1_req = 1'b0;
    for (int i = 0; i < 3; i++) next_slot();
    check_val("t5_sb_drained", 64'(sb_q.size()), 64'd0);

    // 6: reset right after a granted read discards it
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clock);
    check_val("t6_m0_gnt", {63'd0, m0_gnt}, 64'd1);
    next_slot();
    reset_n = 1'b0;
    m0_req = 1'b0;
    @(negedge clock);
    check_val("t6_rst_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
    next_slot();
    next_slot();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val($sformatf("t6_no_rvalid_%0d", i), {63'd0, m0_rvalid}, 64'd0);
      next_slot();
    end
    // fresh IDLE with m0 priority and a cleared burst count
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h60;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h64;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val($sformatf("t6_gnt_%0d", i), {62'd0, m0_gnt, m1_gnt}, (i < 4) ? 64'd2 : 64'd1);
      next_slot();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    next_slot();
    next_slot();
    check_val("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
